// File: rtl/async_lib_pkg.sv
// Shared types and limits for the asynchronous-handshake helper blocks.
// Anything that talks to the async arbiter imports this package.
package async_lib_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      ACK     = 2'd2
   } state_t;

   localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_nff.sv
// N-flop level synchroniser for a single asynchronous bit.
// The flops reset asynchronously to 0.
module sync_nff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw input through the chain; only the last flop is used downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/arbiter_sink_2b_sync.sv
// Clocked receiver for the async arbiter output: synchronises req, presents
// each win as a valid/ready grant, closes the 4-phase handshake and counts grants.
module arbiter_sink_2b_sync
   import async_lib_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_in,
   input  logic             sel_in,
   output logic             ack_out,
   output logic             grant_valid,
   output logic             grant_sel,
   input  logic             grant_ready,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic             proto_err
);

   // A chain shorter than the minimum would not settle metastability, so clamp it.
   localparam int STAGES_EFF = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

   state_t           state_q;
   state_t           state_d;
   logic             req_s;
   logic             ack_d;
   logic             valid_d;
   logic             sel_d;
   logic             err_d;
   logic [CNT_W-1:0] cnt0_d;
   logic [CNT_W-1:0] cnt1_d;

   sync_nff #(
      .STAGES (STAGES_EFF)
   ) u_req_sync (
      .clk (clk),
      .rst (rst),
      .d   (req_in),
      .q   (req_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // All handshake-facing outputs are registered so ack_out is glitch-free to the arbiter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_out     <= 1'b0;
         grant_valid <= 1'b0;
         grant_sel   <= 1'b0;
         proto_err   <= 1'b0;
         cnt0        <= '0;
         cnt1        <= '0;
      end else begin
         ack_out     <= ack_d;
         grant_valid <= valid_d;
         grant_sel   <= sel_d;
         proto_err   <= err_d;
         cnt0        <= cnt0_d;
         cnt1        <= cnt1_d;
      end
   end

   // sel_in is bundled data, valid once req_s is seen, so it is captured only on IDLE->PRESENT.
   always_comb begin
      state_d = state_q;
      ack_d   = ack_out;
      valid_d = grant_valid;
      sel_d   = grant_sel;
      err_d   = proto_err;
      cnt0_d  = cnt0;
      cnt1_d  = cnt1;

      case (state_q)
         IDLE: begin
            ack_d = 1'b0;
            if (req_s) begin
               sel_d   = sel_in;
               valid_d = 1'b1;
               state_d = PRESENT;
            end
         end

         PRESENT: begin
            if (!req_s) begin
               err_d   = 1'b1;
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (grant_ready) begin
               valid_d = 1'b0;
               ack_d   = 1'b1;
               if (grant_sel) begin
                  cnt1_d = cnt1 + CNT_W'(1);
               end else begin
                  cnt0_d = cnt0 + CNT_W'(1);
               end
               state_d = ACK;
            end
         end

         ACK: begin
            if (!req_s) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            ack_d   = 1'b0;
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_arbiter_sink_2b_sync.sv
// Scoreboard bench for arbiter_sink_2b_sync: directed handshakes push expected
// grant sources, a negedge monitor pops them when a grant is accepted.
module tb_arbiter_sink_2b_sync;

   localparam int SS = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_in;
   logic          sel_in;
   logic          ack_out;
   logic          grant_valid;
   logic          grant_sel;
   logic          grant_ready;
   logic [CW-1:0] cnt0;
   logic [CW-1:0] cnt1;
   logic          proto_err;

   int   checks    = 0;
   int   failures  = 0;
   int   accepts   = 0;
   int   ack_rises = 0;
   logic exp_q[$];

   arbiter_sink_2b_sync #(
      .SYNC_STAGES (SS),
      .CNT_W       (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_in      (req_in),
      .sel_in      (sel_in),
      .ack_out     (ack_out),
      .grant_valid (grant_valid),
      .grant_sel   (grant_sel),
      .grant_ready (grant_ready),
      .cnt0        (cnt0),
      .cnt1        (cnt1),
      .proto_err   (proto_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expected source per accepted grant and pairs every ack rise with it.
   initial begin
      logic e;
      logic pending;
      logic ack_prev;
      pending  = 1'b0;
      ack_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pending  = 1'b0;
            ack_prev = 1'b0;
         end else begin
            if (ack_out && !ack_prev) begin
               ack_rises++;
               checkOutput("ack_rise_pairs_accept", {31'd0, pending}, 32'd1);
               pending = 1'b0;
            end
            if (grant_valid && grant_ready) begin
               accepts++;
               pending = 1'b1;
               if (exp_q.size() == 0) begin
                  checkOutput("sb_unexpected_grant", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("sb_grant_sel", {31'd0, grant_sel}, {31'd0, e});
               end
            end
            ack_prev = ack_out;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst         = 1'b1;
      req_in      = 1'b0;
      sel_in      = 1'b0;
      grant_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic waitGrant(input string name);
      int n = 0;
      while (!grant_valid && n < 20) begin
         tick();
         n++;
      end
      if (!grant_valid) checkOutput(name, 32'd0, 32'd1);
   endtask

   task automatic waitAck(input logic lvl, input string name);
      int n = 0;
      while (ack_out !== lvl && n < 20) begin
         tick();
         n++;
      end
      if (ack_out !== lvl) checkOutput(name, {31'd0, ack_out}, {31'd0, lvl});
   endtask

   // One complete 4-phase handshake with the consumer always ready.
   task automatic applyStimulus(input logic sel);
      exp_q.push_back(sel);
      sel_in      = sel;
      req_in      = 1'b1;
      grant_ready = 1'b1;
      waitGrant("hs_grant_timeout");
      waitAck(1'b1, "hs_ack_rise_timeout");
      grant_ready = 1'b0;
      req_in      = 1'b0;
      waitAck(1'b0, "hs_ack_fall_timeout");
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int a0;
      int r0;

      // Reset state
      doReset();
      checkOutput("rst_ack", {31'd0, ack_out}, 32'd0);
      checkOutput("rst_valid", {31'd0, grant_valid}, 32'd0);
      checkOutput("rst_sel", {31'd0, grant_sel}, 32'd0);
      checkOutput("rst_err", {31'd0, proto_err}, 32'd0);
      checkOutput("rst_cnt0", {28'd0, cnt0}, 32'd0);
      checkOutput("rst_cnt1", {28'd0, cnt1}, 32'd0);

      // T1 single grant, exact latencies
      exp_q.push_back(1'b1);
      sel_in      = 1'b1;
      req_in      = 1'b1;
      grant_ready = 1'b1;
      tick(); checkOutput("t1_valid_e1", {31'd0, grant_valid}, 32'd0);
      tick(); checkOutput("t1_valid_e2", {31'd0, grant_valid}, 32'd0);
      tick(); checkOutput("t1_valid_e3", {31'd0, grant_valid}, 32'd1);
      checkOutput("t1_grant_sel", {31'd0, grant_sel}, 32'd1);
      checkOutput("t1_ack_before", {31'd0, ack_out}, 32'd0);
      tick();
      checkOutput("t1_ack_rise", {31'd0, ack_out}, 32'd1);
      checkOutput("t1_valid_drop", {31'd0, grant_valid}, 32'd0);
      checkOutput("t1_cnt1", {28'd0, cnt1}, 32'd1);
      checkOutput("t1_cnt0", {28'd0, cnt0}, 32'd0);
      grant_ready = 1'b0;
      req_in      = 1'b0;
      tick(); checkOutput("t1_ack_hold_e1", {31'd0, ack_out}, 32'd1);
      tick(); checkOutput("t1_ack_hold_e2", {31'd0, ack_out}, 32'd1);
      tick(); checkOutput("t1_ack_fall_e3", {31'd0, ack_out}, 32'd0);

      // T2 backpressure
      doReset();
      exp_q.push_back(1'b0);
      sel_in = 1'b0;
      req_in = 1'b1;
      waitGrant("t2_grant_timeout");
      repeat (10) tick();
      checkOutput("t2_valid_held", {31'd0, grant_valid}, 32'd1);
      checkOutput("t2_ack_low", {31'd0, ack_out}, 32'd0);
      checkOutput("t2_cnt0_held", {28'd0, cnt0}, 32'd0);
      grant_ready = 1'b1;
      tick();
      checkOutput("t2_ack_on_accept", {31'd0, ack_out}, 32'd1);
      checkOutput("t2_cnt0", {28'd0, cnt0}, 32'd1);
      checkOutput("t2_valid_drop", {31'd0, grant_valid}, 32'd0);
      grant_ready = 1'b0;
      req_in      = 1'b0;
      waitAck(1'b0, "t2_ack_fall_timeout");

      // T3 alternating sources
      doReset();
      a0 = accepts;
      r0 = ack_rises;
      for (int i = 0; i < 8; i++) applyStimulus(i[0]);
      tick();
      checkOutput("t3_cnt0", {28'd0, cnt0}, 32'd4);
      checkOutput("t3_cnt1", {28'd0, cnt1}, 32'd4);
      checkOutput("t3_accepts", accepts - a0, 32'd8);
      checkOutput("t3_ack_rises", ack_rises - r0, 32'd8);

      // T4 protocol error, then stickiness across a good handshake
      doReset();
      r0 = ack_rises;
      sel_in = 1'b1;
      req_in = 1'b1;
      waitGrant("t4_grant_timeout");
      req_in = 1'b0;
      tick(); tick(); tick();
      checkOutput("t4_err", {31'd0, proto_err}, 32'd1);
      checkOutput("t4_valid_drop", {31'd0, grant_valid}, 32'd0);
      checkOutput("t4_cnt1", {28'd0, cnt1}, 32'd0);
      checkOutput("t4_cnt0", {28'd0, cnt0}, 32'd0);
      checkOutput("t4_no_ack", ack_rises - r0, 32'd0);
      applyStimulus(1'b0);
      checkOutput("t4_err_sticky", {31'd0, proto_err}, 32'd1);
      checkOutput("t4_cnt0_after", {28'd0, cnt0}, 32'd1);

      // T5 counter wrap with CNT_W=4
      doReset();
      repeat (17) applyStimulus(1'b0);
      checkOutput("t5_cnt0_wrap", {28'd0, cnt0}, 32'd1);
      checkOutput("t5_cnt1", {28'd0, cnt1}, 32'd0);

      // T6 reset during ACK with req still high
      doReset();
      exp_q.push_back(1'b1);
      sel_in      = 1'b1;
      req_in      = 1'b1;
      grant_ready = 1'b1;
      waitGrant("t6_grant_timeout");
      waitAck(1'b1, "t6_ack_rise_timeout");
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("t6_ack_async_drop", {31'd0, ack_out}, 32'd0);
      checkOutput("t6_cnt1_cleared", {28'd0, cnt1}, 32'd0);
      exp_q.push_back(1'b1);
      tick();
      rst = 1'b0;
      tick(); checkOutput("t6_valid_e1", {31'd0, grant_valid}, 32'd0);
      tick(); checkOutput("t6_valid_e2", {31'd0, grant_valid}, 32'd0);
      tick(); checkOutput("t6_regrant_e3", {31'd0, grant_valid}, 32'd1);
      tick();
      checkOutput("t6_ack_again", {31'd0, ack_out}, 32'd1);
      checkOutput("t6_cnt1", {28'd0, cnt1}, 32'd1);
      grant_ready = 1'b0;
      req_in      = 1'b0;
      waitAck(1'b0, "t6_ack_fall_timeout");

      tick();
      checkOutput("sb_queue_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
